// File: rtl/imem_loader.sv
// Serial program loader: assembles big-endian 32-bit words from a byte stream,
// writes them into instruction memory, then verifies a trailing 8-bit checksum byte.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [6:0]    WordCount,
  input  logic [7:0]    ByteIn,
  input  logic          ByteValid,
  output logic          ByteReady,
  output logic          IM_WE,
  output logic [AW-1:0] IM_A,
  output logic [31:0]   IM_WD,
  output logic          CPUReset,
  output logic          Busy,
  output logic          Done,
  output logic          Error
);

  // One extra bit so the written-word count can reach DEPTH without the address wrapping.
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] words_q, words_d;
  logic [1:0]    idx_q,   idx_d;
  logic [31:0]   word_q,  word_d;
  logic [7:0]    csum_q,  csum_d;
  logic          xfer;
  logic [7:0]    csum_sum;

  assign xfer     = ByteValid & ByteReady;
  assign csum_sum = csum_q + ByteIn;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      words_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      words_q <= words_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    words_d = words_q;
    idx_d   = idx_q;
    word_d  = word_q;
    csum_d  = csum_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          if (WordCount == 7'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            count_d = (int'(WordCount) > DEPTH) ? CW'(DEPTH) : CW'(WordCount);
            words_d = '0;
            idx_d   = '0;
            word_d  = '0;
            csum_d  = '0;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          word_d = {word_q[23:0], ByteIn};
          csum_d = csum_sum;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        words_d = words_q + CW'(1);
        state_d = (words_q + CW'(1) == count_q) ? S_CHECK : S_LOAD;
      end
      S_CHECK: begin
        if (xfer) state_d = (csum_sum == 8'd0) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs are pure decodes of registered state.
  assign ByteReady = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign IM_WE     = (state_q == S_WRITE);
  assign IM_A      = words_q[AW-1:0];
  assign IM_WD     = word_q;
  assign CPUReset  = (state_q != S_DONE);
  assign Busy      = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_CHECK);
  assign Done      = (state_q == S_DONE);
  assign Error     = (state_q == S_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a byte-list model predicts the memory writes
// and the final Done/Error outcome of every load.
module tb_imem_loader;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic [6:0]  WordCount = '0;
  logic [7:0]  ByteIn = '0;
  logic        ByteValid = 1'b0;
  logic        ByteReady, IM_WE, CPUReset, Busy, Done, Error;
  logic [5:0]  IM_A;
  logic [31:0] IM_WD;

  imem_loader #(.DEPTH(64), .AW(6)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .WordCount(WordCount),
    .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
    .IM_WE(IM_WE), .IM_A(IM_A), .IM_WD(IM_WD), .CPUReset(CPUReset),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int          wr_a[$];
  logic [31:0] wr_d[$];
  bit          rdy_seen;
  logic [7:0]  stim_q[$];

  always @(negedge Clk) begin
    if (IM_WE) begin
      wr_a.push_back(int'(IM_A));
      wr_d.push_back(IM_WD);
    end
    if (ByteReady) rdy_seen = 1'b1;
  end

  // n data words of random bytes, then a checksum byte that makes the total zero (good) or not.
  function automatic void build(input int n, input bit good);
    logic [7:0] s;
    s = 8'd0;
    stim_q.delete();
    for (int k = 0; k < 4 * n; k++) begin
      stim_q.push_back(8'($urandom));
      s = s + stim_q[k];
    end
    if (good) stim_q.push_back(8'(0) - s);
    else      stim_q.push_back(8'(0) - s + 8'(1 + $urandom_range(0, 254)));
  endfunction

  task automatic run_load(input int wc, input bit gaps, input bit mid, input int lim_in);
    int   n, total, lim, idx, cyc, s;
    bit   good, rdy_prev, mid_done;
    logic [31:0] exp_w;
    n     = (wc > 64) ? 64 : wc;
    total = stim_q.size();
    lim   = (lim_in < 0) ? total : lim_in;
    s = 0;
    foreach (stim_q[k]) s += int'(stim_q[k]);
    good = ((s % 256) == 0);
    wr_a.delete();
    wr_d.delete();
    rdy_seen = 1'b0;

    @(negedge Clk);
    Start = 1'b1; WordCount = 7'(wc); ByteValid = 1'b0;
    @(negedge Clk);
    Start = 1'b0; WordCount = 7'($urandom);
    if (wc == 0) check("zero_done_next", {Done, Busy, CPUReset}, 3'b100);
    else         check("start_busy", {Busy, CPUReset, Done, Error}, 4'b1100);

    idx = 0; cyc = 0; rdy_prev = 1'b0; mid_done = 1'b0;
    if (lim > 0) begin
      forever begin
        // A byte offered but not taken (WRITE) is held unchanged.
        if (!(ByteValid && !rdy_prev)) begin
          if (gaps && $urandom_range(0, 2) == 0) begin
            ByteValid = 1'b0; ByteIn = 8'($urandom);
          end else begin
            ByteValid = 1'b1; ByteIn = stim_q[idx];
          end
        end
        if (mid && !mid_done && Busy && $urandom_range(0, 7) == 0) begin
          Start = 1'b1; WordCount = 7'($urandom_range(0, 127)); mid_done = 1'b1;
        end
        rdy_prev = ByteReady;
        @(negedge Clk);
        cyc++;
        Start = 1'b0;
        if (ByteValid && rdy_prev) idx++;
        if (idx >= lim) break;
        if (cyc > 4000) begin
          check("byte_timeout", 64'(idx), 64'(lim));
          break;
        end
      end
    end
    ByteValid = 1'b0;

    if (lim == total) begin
      if (wc == 0) begin
        ByteValid = 1'b1; ByteIn = 8'($urandom);
        repeat (3) @(negedge Clk);
        ByteValid = 1'b0;
        check("zero_rdy_seen", rdy_seen, 1'b0);
      end
      @(negedge Clk);
      #1;
      check("n_writes", 64'(wr_a.size()), 64'(n));
      for (int i = 0; i < n && i < wr_a.size(); i++) begin
        exp_w = {stim_q[4*i], stim_q[4*i+1], stim_q[4*i+2], stim_q[4*i+3]};
        check("wr_addr", 64'(wr_a[i]), 64'(i));
        check("wr_data", wr_d[i], exp_w);
      end
      check("final_flags", {Busy, Done, Error, CPUReset}, good ? 4'b0100 : 4'b0011);
      $display("load wc=%0d words=%0d writes=%0d good=%0b gaps=%0b mid=%0b Done=%0b Error=%0b",
               wc, n, wr_a.size(), good, gaps, mid, Done, Error);
    end
  endtask

  initial begin
    #1;
    check("rst_outs", {ByteReady, IM_WE, IM_A, IM_WD, CPUReset, Busy, Done, Error},
          {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 3'b000});
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    check("idle_after_rst", {ByteReady, Busy, Done, Error, CPUReset}, 5'b00001);

    // Known program word with a correct checksum.
    stim_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hD3};
    run_load(1, 1'b0, 1'b0, -1);
    if (wr_d.size() > 0) check("wd_20080005", wr_d[0], 32'h20080005);

    // Same word, wrong checksum, then a restart from ERROR.
    stim_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00};
    run_load(1, 1'b0, 1'b0, -1);
    build(2, 1'b1);
    run_load(2, 1'b1, 1'b0, -1);

    // Oversized count is clamped to the memory depth.
    build(64, 1'b1);
    run_load(100, 1'b0, 1'b0, -1);

    for (int t = 0; t < 6; t++) begin
      int wc;
      wc = int'($urandom_range(1, 80));
      build((wc > 64) ? 64 : wc, bit'($urandom_range(0, 1)));
      run_load(wc, 1'b1, 1'b1, -1);
    end

    stim_q.delete();
    run_load(0, 1'b0, 1'b0, -1);

    // Reset in the middle of word 3 (after its second byte).
    build(5, 1'b1);
    run_load(5, 1'b0, 1'b0, 14);
    #2 Reset_n = 1'b0;
    #1;
    check("rst_async_outs", {ByteReady, IM_WE, IM_A, IM_WD, CPUReset, Busy, Done, Error},
          {1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 3'b000});
    @(negedge Clk);
    Reset_n = 1'b1;
    ByteValid = 1'b1; ByteIn = 8'h5A;
    repeat (5) @(negedge Clk);
    #1;
    check("idle_after_midrst", {ByteReady, Busy, Done, Error, CPUReset}, 5'b00001);
    check("midrst_writes", 64'(wr_a.size()), 64'd3);
    ByteValid = 1'b0;
    $display("reset mid-load: writes=%0d", wr_a.size());

    build(3, 1'b1);
    run_load(3, 1'b1, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
